// File: rtl/pinmux_ctrl.sv
// rtl/pinmux_ctrl.sv - register-programmable pad/peripheral multiplexer with sync, glitch filter and lock
module pinmux_ctrl #(
    parameter int NPads      = 66,
    parameter int NPeriphOut = 48,
    parameter int NPeriphIn  = 24,
    parameter int FilterW    = 4,
    localparam int AddrW     = $clog2(NPads + NPeriphIn + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  reg_req_i,
    input  logic                  reg_we_i,
    input  logic [AddrW-1:0]      reg_addr_i,
    input  logic [31:0]           reg_wdata_i,
    output logic [31:0]           reg_rdata_o,
    output logic                  reg_ack_o,
    output logic                  reg_err_o,
    input  logic [NPeriphOut-1:0] periph_out_i,
    input  logic [NPeriphOut-1:0] periph_oe_i,
    output logic [NPeriphIn-1:0]  periph_in_o,
    input  logic [NPads-1:0]      pad_in_i,
    output logic [NPads-1:0]      pad_out_o,
    output logic [NPads-1:0]      pad_oe_o
);

    localparam int OutSelW = $clog2(NPeriphOut + 1);
    localparam int InSelW  = $clog2(NPads + 2);
    localparam logic [AddrW-1:0]   LockAddr = AddrW'(NPads + NPeriphIn);
    localparam logic [FilterW-1:0] FiltMax  = '1;

    logic [OutSelW-1:0] outsel_q   [NPads];
    logic [InSelW-1:0]  insel_q    [NPeriphIn];
    logic [FilterW-1:0] filt_cnt_q [NPeriphIn];
    logic [NPeriphIn-1:0] filt_en_q;
    logic                 lock_q;
    logic [NPads-1:0]     sync1_q;
    logic [NPads-1:0]     sync2_q;
    logic                 ack_q;
    logic                 err_q;
    logic [31:0]          rdata_q;

    logic [NPads-1:0]     hit_out;
    logic [NPeriphIn-1:0] hit_in;
    logic                 hit_lock;
    logic                 addr_bad;
    logic                 sel_bad;
    logic                 lock_bad;
    logic                 acc_err;
    logic                 wr_en;
    logic [31:0]          rd_val;
    logic [NPeriphIn-1:0] mux_val;

    // Address decode, read data, select-range and lock checks for the current request
    always_comb begin
        hit_out  = '0;
        hit_in   = '0;
        rd_val   = '0;
        sel_bad  = 1'b0;
        hit_lock = (reg_addr_i == LockAddr);
        addr_bad = (reg_addr_i > LockAddr);
        for (int p = 0; p < NPads; p++) begin
            if (reg_addr_i == AddrW'(p)) begin
                hit_out[p]            = 1'b1;
                rd_val[OutSelW-1:0]   = outsel_q[p];
                if (reg_wdata_i[OutSelW-1:0] > OutSelW'(NPeriphOut)) sel_bad = 1'b1;
            end
        end
        for (int i = 0; i < NPeriphIn; i++) begin
            if (reg_addr_i == AddrW'(NPads + i)) begin
                hit_in[i]            = 1'b1;
                rd_val[InSelW-1:0]   = insel_q[i];
                rd_val[31]           = filt_en_q[i];
                if (reg_wdata_i[InSelW-1:0] > InSelW'(NPads + 1)) sel_bad = 1'b1;
            end
        end
        if (hit_lock) rd_val[0] = lock_q;
        lock_bad = lock_q && !hit_lock;
        acc_err  = addr_bad || (reg_we_i && (sel_bad || lock_bad));
        wr_en    = reg_req_i && reg_we_i && !acc_err;
    end

    // Register file and one-cycle response; accepted writes land on the ack edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < NPads; p++) outsel_q[p] <= '0;
            for (int i = 0; i < NPeriphIn; i++) insel_q[i] <= '0;
            filt_en_q <= '0;
            lock_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            ack_q   <= reg_req_i;
            err_q   <= reg_req_i && acc_err;
            rdata_q <= (reg_req_i && !reg_we_i && !acc_err) ? rd_val : '0;
            if (wr_en) begin
                for (int p = 0; p < NPads; p++) begin
                    if (hit_out[p]) outsel_q[p] <= reg_wdata_i[OutSelW-1:0];
                end
                for (int i = 0; i < NPeriphIn; i++) begin
                    if (hit_in[i]) begin
                        insel_q[i]   <= reg_wdata_i[InSelW-1:0];
                        filt_en_q[i] <= reg_wdata_i[31];
                    end
                end
                if (hit_lock && reg_wdata_i[0]) lock_q <= 1'b1;
            end
        end
    end

    // A response still in flight when reset arrives is dropped
    assign reg_ack_o   = ack_q && !rst_i;
    assign reg_err_o   = err_q && !rst_i;
    assign reg_rdata_o = rst_i ? '0 : rdata_q;

    // Pad input synchroniser and registered pad drivers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            pad_out_o <= '0;
            pad_oe_o  <= '0;
        end else begin
            sync1_q <= pad_in_i;
            sync2_q <= sync1_q;
            for (int p = 0; p < NPads; p++) begin
                pad_out_o[p] <= 1'b0;
                pad_oe_o[p]  <= 1'b0;
                for (int k = 0; k < NPeriphOut; k++) begin
                    if (outsel_q[p] == OutSelW'(k + 1)) begin
                        pad_out_o[p] <= periph_out_i[k];
                        pad_oe_o[p]  <= periph_oe_i[k];
                    end
                end
            end
        end
    end

    // Peripheral input source select: constants come straight from the register
    always_comb begin
        mux_val = '0;
        for (int i = 0; i < NPeriphIn; i++) begin
            if (insel_q[i] == InSelW'(1)) mux_val[i] = 1'b1;
            for (int k = 0; k < NPads; k++) begin
                if (insel_q[i] == InSelW'(k + 2)) mux_val[i] = sync2_q[k];
            end
        end
    end

    // Glitch filter: a differing level must persist a full counter span before it is taken
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            periph_in_o <= '0;
            for (int i = 0; i < NPeriphIn; i++) filt_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NPeriphIn; i++) begin
                if (!filt_en_q[i]) begin
                    periph_in_o[i] <= mux_val[i];
                    filt_cnt_q[i]  <= '0;
                end else if (wr_en && hit_in[i]) begin
                    filt_cnt_q[i]  <= '0;
                end else if (mux_val[i] == periph_in_o[i]) begin
                    filt_cnt_q[i]  <= '0;
                end else if (filt_cnt_q[i] == FiltMax) begin
                    periph_in_o[i] <= mux_val[i];
                    filt_cnt_q[i]  <= '0;
                end else begin
                    filt_cnt_q[i]  <= filt_cnt_q[i] + FilterW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pinmux_ctrl.sv
// tb/tb_pinmux_ctrl.sv - directed self-checking bench for pinmux_ctrl
module tb_pinmux_ctrl;

    localparam int NPads      = 66;
    localparam int NPeriphOut = 48;
    localparam int NPeriphIn  = 24;
    localparam int AddrW      = 7;
    localparam int LockA      = NPads + NPeriphIn;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  req;
    logic                  we;
    logic [AddrW-1:0]      addr;
    logic [31:0]           wdata;
    logic [31:0]           rdata;
    logic                  ack;
    logic                  err;
    logic [NPeriphOut-1:0] pout;
    logic [NPeriphOut-1:0] poe;
    logic [NPeriphIn-1:0]  pin;
    logic [NPads-1:0]      padin;
    logic [NPads-1:0]      padout;
    logic [NPads-1:0]      padoe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pinmux_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .reg_req_i    (req),
        .reg_we_i     (we),
        .reg_addr_i   (addr),
        .reg_wdata_i  (wdata),
        .reg_rdata_o  (rdata),
        .reg_ack_o    (ack),
        .reg_err_o    (err),
        .periph_out_i (pout),
        .periph_oe_i  (poe),
        .periph_in_o  (pin),
        .pad_in_i     (padin),
        .pad_out_o    (padout),
        .pad_oe_o     (padoe)
    );

    // Single access; returns the response sampled at the negedge of the ack cycle
    task automatic access(input logic a_we, input int a_addr, input logic [31:0] a_wdata,
                          output logic r_ack, output logic r_err, output logic [31:0] r_rdata);
        @(posedge clk); #1;
        req = 1'b1; we = a_we; addr = AddrW'(a_addr); wdata = a_wdata;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; wdata = '0;
        @(negedge clk);
        r_ack = ack; r_err = err; r_rdata = rdata;
    endtask

    task automatic test_reset();
        logic a, e; logic [31:0] d;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ack, err, padout, padoe, pin} !== '0) begin
            errors++; $display("FAIL reset_outputs: ack=%b err=%b padout=%h padoe=%h pin=%h required all 0", ack, err, padout, padoe, pin);
        end
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i <= LockA; i++) begin
            access(1'b0, i, 32'h0, a, e, d);
            checks++;
            if ({a, e, d} !== {1'b1, 1'b0, 32'h0}) begin
                errors++; $display("FAIL reset_read addr=%0d: ack=%b err=%b rdata=%h required 1 0 0", i, a, e, d);
            end
        end
        access(1'b0, LockA + 1, 32'h0, a, e, d);
        checks++;
        if ({a, e, d} !== {1'b1, 1'b1, 32'h0}) begin
            errors++; $display("FAIL bad_addr: ack=%b err=%b rdata=%h required 1 1 0", a, e, d);
        end
    endtask

    task automatic test_outsel();
        logic a, e; logic [31:0] d;
        pout[2] = 1'b1; poe[2] = 1'b1;
        access(1'b1, 5, 32'd3, a, e, d);
        checks++;
        if ({a, e, padout[5], padoe[5]} !== 4'b1000) begin
            errors++; $display("FAIL outsel_ack_cycle: ack=%b err=%b out=%b oe=%b required 1 0 0 0", a, e, padout[5], padoe[5]);
        end
        @(negedge clk);
        checks++;
        if ({padout[5], padoe[5], padout[4], padoe[4]} !== 4'b1100) begin
            errors++; $display("FAIL outsel_effect: pad5=%b/%b pad4=%b/%b required 1/1 0/0", padout[5], padoe[5], padout[4], padoe[4]);
        end
        access(1'b1, 7, 32'd3, a, e, d);
        @(negedge clk);
        checks++;
        if ({padout[7], padoe[7], padout[5]} !== 3'b111) begin
            errors++; $display("FAIL outsel_fanout: pad7=%b/%b pad5=%b required 1/1 1", padout[7], padoe[7], padout[5]);
        end
        access(1'b1, 5, 32'd49, a, e, d);
        checks++;
        if ({a, e, d} !== {1'b1, 1'b1, 32'h0}) begin
            errors++; $display("FAIL outsel_range: ack=%b err=%b rdata=%h required 1 1 0", a, e, d);
        end
        access(1'b0, 5, 32'h0, a, e, d);
        checks++;
        if ({e, d} !== {1'b0, 32'd3}) begin
            errors++; $display("FAIL outsel_readback: err=%b rdata=%h required 0 3", e, d);
        end
        @(posedge clk); #1; pout[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (padout[5] !== 1'b1) begin
            errors++; $display("FAIL periph_latency_hold: pad5=%b required 1", padout[5]);
        end
        @(negedge clk);
        checks++;
        if ({padout[5], padout[7], padoe[5]} !== 3'b001) begin
            errors++; $display("FAIL periph_latency: pad5=%b pad7=%b oe5=%b required 0 0 1", padout[5], padout[7], padoe[5]);
        end
    endtask

    task automatic test_insel();
        logic a, e; logic [31:0] d;
        logic v;
        access(1'b1, NPads, 32'd12, a, e, d);
        checks++;
        if ({a, e, pin[0]} !== 3'b100) begin
            errors++; $display("FAIL insel_write: ack=%b err=%b pin0=%b required 1 0 0", a, e, pin[0]);
        end
        for (int edge_n = 0; edge_n < 2; edge_n++) begin
            v = (edge_n == 0);
            @(posedge clk); #1; padin[10] = v;
            for (int n = 0; n < 4; n++) begin
                @(negedge clk);
                checks++;
                if (pin[0] !== ((n >= 3) ? v : ~v)) begin
                    errors++; $display("FAIL insel_follow edge=%0d cyc=%0d: pin0=%b required %b", edge_n, n, pin[0], (n >= 3) ? v : ~v);
                end
            end
        end
        access(1'b1, NPads, 32'd1, a, e, d);
        checks++;
        if (pin[0] !== 1'b0) begin
            errors++; $display("FAIL const_ack_cycle: pin0=%b required 0", pin[0]);
        end
        @(negedge clk);
        checks++;
        if (pin[0] !== 1'b1) begin
            errors++; $display("FAIL const_one: pin0=%b required 1", pin[0]);
        end
        access(1'b1, NPads + 1, 32'd68, a, e, d);
        checks++;
        if ({a, e} !== 2'b11) begin
            errors++; $display("FAIL insel_range: ack=%b err=%b required 1 1", a, e);
        end
    endtask

    task automatic test_filter();
        logic a, e; logic [31:0] d;
        access(1'b1, NPads, 32'h8000_000C, a, e, d);
        access(1'b0, NPads, 32'h0, a, e, d);
        checks++;
        if ({e, d} !== {1'b0, 32'h8000_000C}) begin
            errors++; $display("FAIL filt_readback: err=%b rdata=%h required 0 8000000c", e, d);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (pin[0] !== 1'b0) begin
            errors++; $display("FAIL filt_settle: pin0=%b required 0", pin[0]);
        end
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1; padin[10] = (n < 10);
            @(negedge clk);
            checks++;
            if (pin[0] !== 1'b0) begin
                errors++; $display("FAIL filt_pulse cyc=%0d: pin0=%b required 0", n, pin[0]);
            end
        end
        for (int n = 0; n < 24; n++) begin
            @(posedge clk); #1; padin[10] = 1'b1;
            @(negedge clk);
            checks++;
            if (pin[0] !== (n >= 18)) begin
                errors++; $display("FAIL filt_level cyc=%0d: pin0=%b required %b", n, pin[0], n >= 18);
            end
        end
    endtask

    task automatic test_lock();
        logic a, e; logic [31:0] d;
        access(1'b1, LockA, 32'd1, a, e, d);
        checks++;
        if ({a, e} !== 2'b10) begin
            errors++; $display("FAIL lock_set: ack=%b err=%b required 1 0", a, e);
        end
        access(1'b1, 0, 32'd1, a, e, d);
        checks++;
        if ({a, e, d} !== {1'b1, 1'b1, 32'h0}) begin
            errors++; $display("FAIL locked_outsel: ack=%b err=%b rdata=%h required 1 1 0", a, e, d);
        end
        access(1'b1, NPads, 32'd0, a, e, d);
        checks++;
        if (e !== 1'b1) begin
            errors++; $display("FAIL locked_insel: err=%b required 1", e);
        end
        access(1'b0, 0, 32'h0, a, e, d);
        checks++;
        if ({e, d} !== {1'b0, 32'h0}) begin
            errors++; $display("FAIL locked_outsel_keep: err=%b rdata=%h required 0 0", e, d);
        end
        access(1'b1, LockA, 32'd0, a, e, d);
        checks++;
        if ({a, e} !== 2'b10) begin
            errors++; $display("FAIL lock_clear_write: ack=%b err=%b required 1 0", a, e);
        end
        access(1'b0, LockA, 32'h0, a, e, d);
        checks++;
        if (d !== 32'd1) begin
            errors++; $display("FAIL lock_sticky: rdata=%h required 1", d);
        end
        @(posedge clk); #1; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        access(1'b0, LockA, 32'h0, a, e, d);
        checks++;
        if ({e, d} !== {1'b0, 32'h0}) begin
            errors++; $display("FAIL lock_reset: err=%b rdata=%h required 0 0", e, d);
        end
    endtask

    task automatic test_back_to_back();
        logic a, e; logic [31:0] d;
        access(1'b1, 3, 32'd17, a, e, d);
        @(posedge clk); #1; req = 1'b1; we = 1'b0; addr = 7'd3;
        @(posedge clk); #1; we = 1'b1; addr = 7'd67; wdata = 32'd5;
        @(negedge clk);
        checks++;
        if ({ack, err, rdata} !== {1'b1, 1'b0, 32'd17}) begin
            errors++; $display("FAIL b2b_first: ack=%b err=%b rdata=%h required 1 0 11", ack, err, rdata);
        end
        @(posedge clk); #1; req = 1'b0; we = 1'b0; wdata = '0;
        @(negedge clk);
        checks++;
        if ({ack, err, rdata} !== {1'b1, 1'b0, 32'h0}) begin
            errors++; $display("FAIL b2b_second: ack=%b err=%b rdata=%h required 1 0 0", ack, err, rdata);
        end
        @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: ack=%b required 0", ack);
        end
        access(1'b0, 67, 32'h0, a, e, d);
        checks++;
        if (d !== 32'd5) begin
            errors++; $display("FAIL b2b_write: rdata=%h required 5", d);
        end
        @(posedge clk); #1; req = 1'b1; addr = 7'd3;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (ack !== 1'b1) begin
            errors++; $display("FAIL rst_first_ack: ack=%b required 1", ack);
        end
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ack, err, rdata} !== {1'b0, 1'b0, 32'h0}) begin
            errors++; $display("FAIL rst_suppress: ack=%b err=%b rdata=%h required 0 0 0", ack, err, rdata);
        end
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b0; req = 1'b0;
        @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin
            errors++; $display("FAIL rst_req_during: ack=%b required 0", ack);
        end
        access(1'b0, 3, 32'h0, a, e, d);
        checks++;
        if ({a, e, d} !== {1'b1, 1'b0, 32'h0}) begin
            errors++; $display("FAIL rst_clears_outsel: ack=%b err=%b rdata=%h required 1 0 0", a, e, d);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        pout = '0; poe = '0; padin = '0;
        test_reset();
        test_outsel();
        test_insel();
        test_filter();
        test_lock();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
